hazard_ctrl: RTL

Pipeline hazard controller for the five-stage RISC-V core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and drives their write-enable and flush/bubble controls. It handles three cases: load-use stalls, taken-branch flushes, and data-memory wait states. A watchdog counter declares a fatal timeout if the data memory never returns ready.

---
 rtl/hazard_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage RISC-V core.
//
// Drives the write-enable and flush/bubble controls of the IF/ID, ID/EX,
// EX/MEM and MEM/WB stage registers. Handles load-use stalls, taken-branch
// flushes and data-memory wait states, and raises a sticky fatal flag when the
// data memory keeps the pipe waiting for MEM_TIMEOUT consecutive cycles.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Defined   -> adds stall_cycles, loaduse_count and flush_count counters.
//   Undefined -> counter ports and registers are not built.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   id_rs1, id_rs2  source registers of the instruction in ID
//   ex_rd           destination register of the instruction in EX
//   ex_MemRead      instruction in EX is a load
//   ex_branch_taken EX resolved a taken branch this cycle
//   mem_req         MEM stage issues a load/store
//   mem_ready       data memory completes the access this cycle
//   pc_write        PC update enable
//   if_id_write     IF/ID load enable
//   if_id_flush     IF/ID clears to NOP on the next edge
//   id_ex_write     ID/EX load enable
//   id_ex_flush     ID/EX control fields zeroed on the next edge (bubble)
//   ex_mem_write    EX/MEM load enable
//   mem_wb_bubble   MEM/WB captures RegWrite=0, MemtoReg=0
//   mem_timeout     sticky fatal memory timeout flag
//   stall_cycles    (perf) cycles with a memory stall
//   loaduse_count   (perf) cycles where a load-use stall won arbitration
//   flush_count     (perf) cycles where a taken branch won arbitration

module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 200,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_MemRead,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_write,
  output logic        mem_wb_bubble,
  output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] loaduse_count,
  output logic [31:0] flush_count
`endif
);

  // State encoding kept as plain constants for compatibility with older tools.
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);

  logic [1:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_stall;
  logic load_use;
  logic halted;

  // Arbitration winners, mutually exclusive by construction.
  logic win_stall;
  logic win_branch;
  logic win_load_use;

  //--------------------------------------------------------------------------
  // Hazard detection
  //--------------------------------------------------------------------------
  assign mem_stall = mem_req & ~mem_ready;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_MemRead & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign halted = (state_q == HALT);

  // A stall freezes EX and ID, so any branch or load-use seen during it is
  // simply re-evaluated on the cycle the stall releases.
  assign win_stall    = ~halted & mem_stall;
  assign win_branch   = ~halted & ~mem_stall & ex_branch_taken;
  assign win_load_use = ~halted & ~mem_stall & ~ex_branch_taken & load_use;

  //--------------------------------------------------------------------------
  // Control outputs (combinational, forced low while reset is asserted)
  //--------------------------------------------------------------------------
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    mem_timeout   = 1'b0;

    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (halted) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_timeout  = 1'b1;
    end else if (win_stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (win_branch) begin
      // Both younger instructions are on the wrong path.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (win_load_use) begin
      // Hold PC and IF/ID, insert one bubble into ID/EX.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // State machine and memory-wait watchdog
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!halted) begin
      if (!mem_stall) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != CNT_MAX) begin
        wait_cnt_d = wait_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  //--------------------------------------------------------------------------
  // Performance counters (wrap modulo 2^32, frozen in HALT)
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles  <= '0;
      loaduse_count <= '0;
      flush_count   <= '0;
    end else begin
      if (win_stall)    stall_cycles  <= stall_cycles + 32'd1;
      if (win_load_use) loaduse_count <= loaduse_count + 32'd1;
      if (win_branch)   flush_count   <= flush_count + 32'd1;
    end
  end
`endif

endmodule
